// File: rtl/alu_pkg.sv
// alu_pkg: shared instruction classes, sequencer states, field positions and op encoding for the ALU sequencer.
package alu_pkg;
  typedef enum logic [2:0] {
    C_NOP, C_ADDSUB, C_MUL, C_LOGIC, C_LSH, C_RSH, C_LDI, C_HALT
  } cls_e;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPND, S_EXEC, S_HALT
  } state_e;
  localparam int CLS_LSB = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  localparam int IMM_BIT = 3;
  // one-hot order follows the class codes: ADDSUB=bit0 .. RSH=bit4
  function automatic logic [4:0] op_onehot(cls_e c);
    return (c >= C_ADDSUB && c <= C_RSH) ? 5'(5'd1 << (c - C_ADDSUB)) : 5'd0;
  endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational split of an instruction word into class, register indices, params and operand kind.
module alu_decode
  import alu_pkg::*;
(
  input  logic [15:0] word_i,
  output cls_e        cls_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rs1_o,
  output logic [2:0]  rs2_o,
  output logic [3:0]  params_o,
  output logic [4:0]  op_o,
  output logic        needs_imm_o,
  output logic        reg_op_o
);
  assign cls_o    = cls_e'(word_i[CLS_LSB +: 3]);
  assign rd_o     = word_i[RD_LSB +: 3];
  assign rs1_o    = word_i[RS1_LSB +: 3];
  assign rs2_o    = word_i[RS2_LSB +: 3];
  assign params_o = word_i[3:0];
  assign op_o     = op_onehot(cls_o);
  // shifts use params as the amount, so only ADDSUB/MUL/LOGIC can take a literal operand
  assign needs_imm_o = cls_o == C_LDI ||
                       ((cls_o == C_ADDSUB || cls_o == C_MUL || cls_o == C_LOGIC) && word_i[IMM_BIT]);
  assign reg_op_o = op_o != 5'd0 && !needs_imm_o;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/issue controller driving the 8x16 register ALU from program memory.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int AW          = 8,
  parameter bit HALT_ON_OVF = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic          fetch_req,
  output logic [AW-1:0] fetch_addr,
  input  logic          fetch_ack,
  input  logic [15:0]   fetch_data,
  output logic [2:0]    alu_operand1,
  output logic [2:0]    alu_operand2,
  output logic [2:0]    alu_result,
  output logic [5:0]    alu_operation,
  output logic [3:0]    alu_params,
  output logic          alu_immediate,
  output logic          alu_readbus,
  output logic [15:0]   alu_din,
  input  logic          alu_overflow,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc
);
  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d, din_q, din_d;
  cls_e          cls;
  logic [4:0]    op;
  logic          needs_imm, reg_op, exec;
  alu_decode u_dec (
    .word_i      (ir_q),
    .cls_o       (cls),
    .rd_o        (alu_result),
    .rs1_o       (alu_operand1),
    .rs2_o       (alu_operand2),
    .params_o    (alu_params),
    .op_o        (op),
    .needs_imm_o (needs_imm),
    .reg_op_o    (reg_op)
  );
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      din_q   <= din_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    din_d   = din_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) begin
        state_d = S_FETCH;
        pc_d    = start_addr;
      end
      S_FETCH: if (fetch_ack) begin
        ir_d    = fetch_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = cls == C_NOP ? S_FETCH : cls == C_HALT ? S_HALT : needs_imm ? S_OPND : S_EXEC;
      S_OPND: if (fetch_ack) begin
        din_d   = fetch_data;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = (HALT_ON_OVF && alu_overflow) ? S_HALT : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    exec          = state_q == S_EXEC;
    fetch_req     = state_q == S_FETCH || state_q == S_OPND;
    fetch_addr    = pc_q;
    alu_operation = exec ? {1'b1, op} : 6'd0;
    alu_immediate = exec && reg_op;
    alu_readbus   = exec && needs_imm;
    alu_din       = din_q;
    busy          = !(state_q == S_IDLE || state_q == S_HALT);
    halted        = state_q == S_HALT;
    pc            = pc_q;
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs with an expected-EXEC scoreboard checked by a separate monitor.
module tb_alu_sequencer;
  import alu_pkg::*;
  logic        CLK = 0, RST = 1, start = 0, fetch_ack = 0, alu_overflow = 0;
  logic [7:0]  start_addr = 0;
  logic [15:0] fetch_data = 0;
  logic        fetch_req, alu_immediate, alu_readbus, busy, halted;
  logic [7:0]  fetch_addr, pc;
  logic [2:0]  alu_operand1, alu_operand2, alu_result;
  logic [5:0]  alu_operation;
  logic [3:0]  alu_params;
  logic [15:0] alu_din;
  logic [15:0] mem [256];
  int          ack_delay = 0, wcnt = 0, n_chk = 0, n_pass = 0;
  typedef struct {
    logic [5:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [3:0]  p;
    logic        imm, rb;
    logic [15:0] din;
    logic [7:0]  pc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  alu_sequencer #(.AW(8), .HALT_ON_OVF(1'b1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .start_addr(start_addr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_result(alu_result),
    .alu_operation(alu_operation), .alu_params(alu_params), .alu_immediate(alu_immediate),
    .alu_readbus(alu_readbus), .alu_din(alu_din), .alu_overflow(alu_overflow),
    .busy(busy), .halted(halted), .pc(pc)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic [3:0] p, input logic imm, input logic rb, input logic [15:0] din, input logic [7:0] npc);
    exp_t x;
    x.op = op; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.p = p; x.imm = imm; x.rb = rb; x.din = din; x.pc = npc;
    sb.push_back(x);
  endtask

  task automatic pulse_start(input logic [7:0] a);
    @(negedge CLK);
    start_addr = a;
    start = 1;
    @(negedge CLK);
    start = 0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(name, halted, 1);
  endtask

  // program memory: answers a pending request after ack_delay idle cycles
  initial forever begin
    @(negedge CLK);
    if (fetch_ack) begin
      fetch_ack = 0;
      wcnt = 0;
    end else if (fetch_req) begin
      if (wcnt >= ack_delay) begin
        fetch_ack = 1;
        fetch_data = mem[fetch_addr];
      end else wcnt++;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (alu_operation[5] === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_exec: got op %b expected no ALU write", alu_operation);
      end else begin
        e = sb.pop_front();
        check("exec_op", alu_operation, e.op);
        check("exec_rd", alu_result, e.rd);
        check("exec_rs1", alu_operand1, e.rs1);
        check("exec_rs2", alu_operand2, e.rs2);
        check("exec_params", alu_params, e.p);
        check("exec_immediate", alu_immediate, e.imm);
        check("exec_readbus", alu_readbus, e.rb);
        if (e.rb) check("exec_din", alu_din, e.din);
        check("exec_pc", pc, e.pc);
      end
    end
  end

  initial begin
    foreach (mem[i]) mem[i] = 16'hE000;
    #1;
    check("rst_fetch_req", fetch_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_op", alu_operation, 0);
    repeat (2) @(negedge CLK);
    RST = 0;

    // register ADD b+c into a, then NOP, then HALT
    mem[8'h50] = 16'h20A0; mem[8'h51] = 16'h0000; mem[8'h52] = 16'hE000;
    ack_delay = 1;
    push(6'b100001, 3'd0, 3'd1, 3'd2, 4'd0, 1'b1, 1'b0, 16'h0, 8'h51);
    pulse_start(8'h50);
    check("add_busy", busy, 1);
    wait_halt("add_halt");
    check("add_pc", pc, 8'h53);
    check("add_busy_off", busy, 0);

    // immediate SUB: operand2 is the following word
    mem[8'h10] = 16'h2089; mem[8'h11] = 16'h0003; mem[8'h12] = 16'hE000;
    ack_delay = 0;
    push(6'b100001, 3'd0, 3'd1, 3'd0, 4'd9, 1'b0, 1'b1, 16'h0003, 8'h12);
    pulse_start(8'h10);
    wait_halt("sub_halt");
    check("sub_pc", pc, 8'h13);

    // LDI b <= 0xBEEF then HALT; no fetching afterwards
    mem[8'h20] = 16'hC400; mem[8'h21] = 16'hBEEF; mem[8'h22] = 16'hE000;
    push(6'b100000, 3'd1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 16'hBEEF, 8'h22);
    pulse_start(8'h20);
    wait_halt("ldi_halt");
    check("ldi_busy", busy, 0);
    repeat (5) begin
      @(negedge CLK);
      check("halt_no_fetch", fetch_req, 0);
    end

    // PC wrap with a slow memory: LSH at 0xFF, HALT at 0x00
    mem[8'hFF] = 16'h8013;
    ack_delay = 4;
    push(6'b101000, 3'd0, 3'd0, 3'd1, 4'd3, 1'b1, 1'b0, 16'h0, 8'h00);
    pulse_start(8'hFF);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("stall_req", fetch_req, 1);
      check("stall_addr", fetch_addr, 8'hFF);
      @(negedge CLK);
      #1;
    end
    begin
      int n = 0;
      while (n < 200 && !(fetch_req && fetch_addr != 8'hFF)) begin
        @(negedge CLK);
        n++;
      end
    end
    check("wrap_req", fetch_req, 1);
    check("wrap_addr", fetch_addr, 8'h00);
    wait_halt("wrap_halt");
    check("wrap_pc", pc, 8'h01);

    // MUL with overflow flag high in EXEC halts instead of fetching the NOP
    mem[8'h30] = 16'h4000; mem[8'h31] = 16'h0000;
    ack_delay = 0;
    alu_overflow = 1;
    push(6'b100010, 3'd0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 16'h0, 8'h31);
    pulse_start(8'h30);
    wait_halt("ovf_halt");
    check("ovf_pc", pc, 8'h31);
    alu_overflow = 0;

    // reset while waiting for an immediate word
    mem[8'h40] = 16'h2089; mem[8'h41] = 16'h0005;
    ack_delay = 10;
    pulse_start(8'h40);
    begin
      int n = 0;
      while (n < 200 && !(fetch_req && fetch_addr == 8'h41)) begin
        @(negedge CLK);
        n++;
      end
    end
    check("opnd_reached", fetch_req && fetch_addr == 8'h41, 1);
    #2 RST = 1;
    #1;
    check("rst_mid_req", fetch_req, 0);
    check("rst_mid_pc", pc, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_op", alu_operation, 0);
    repeat (3) @(negedge CLK);
    RST = 0;
    repeat (3) @(negedge CLK);
    check("idle_after_rst", busy, 0);
    check("idle_not_halted", halted, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
